// File: rtl/alu_result_stage.sv
// Registered result stage after the ALU: 2-entry skid buffer toward writeback
// plus the architectural NZCV flag register.
module alu_result_stage #(
  parameter int N  = 4,
  parameter int RW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [N-1:0]  result_i,
  input  logic          cout_i,
  input  logic          overflow_i,
  input  logic [RW-1:0] rd_i,
  input  logic          set_flags_i,
  input  logic          flush_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [N-1:0]  result_o,
  output logic [RW-1:0] rd_o,
  output logic [3:0]    flags_o
);

  logic          main_valid;
  logic [N-1:0]  main_result;
  logic [RW-1:0] main_rd;
  logic          skid_valid;
  logic [N-1:0]  skid_result;
  logic [RW-1:0] skid_rd;
  logic [3:0]    flags;
  logic          accept;
  logic          drain;

  function automatic logic [3:0] nzcv(input logic [N-1:0] r, input logic c, input logic v);
    return {r[N-1], (r == '0), c, v};
  endfunction

  // Ready depends only on registered state, so no out_ready_i -> in_ready_o path.
  assign in_ready_o  = ~skid_valid;
  assign out_valid_o = main_valid;
  assign result_o    = main_result;
  assign rd_o        = main_rd;
  assign flags_o     = flags;
  assign accept      = in_valid_i & in_ready_o;
  assign drain       = main_valid & out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_valid  <= 1'b0;
      main_result <= '0;
      main_rd     <= '0;
      skid_valid  <= 1'b0;
      skid_result <= '0;
      skid_rd     <= '0;
      flags       <= 4'b0000;
    end else if (flush_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (accept && set_flags_i) begin
        flags <= nzcv(result_i, cout_i, overflow_i);
      end
      if (!main_valid) begin
        if (accept) begin
          main_valid  <= 1'b1;
          main_result <= result_i;
          main_rd     <= rd_i;
        end
      end else if (!skid_valid) begin
        if (drain && accept) begin
          main_result <= result_i;
          main_rd     <= rd_i;
        end else if (drain) begin
          main_valid <= 1'b0;
        end else if (accept) begin
          skid_valid  <= 1'b1;
          skid_result <= result_i;
          skid_rd     <= rd_i;
        end
      end else if (drain) begin
        // Full: the skid entry moves up; nothing can be accepted this cycle.
        main_result <= skid_result;
        main_rd     <= skid_rd;
        skid_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: hand-computed expectations checked
// with immediate assertions along a single linear stimulus sequence.
module tb_alu_result_stage;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [3:0] result_i;
  logic       cout_i;
  logic       overflow_i;
  logic [3:0] rd_i;
  logic       set_flags_i;
  logic       flush_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [3:0] result_o;
  logic [3:0] rd_o;
  logic [3:0] flags_o;

  int checks = 0;
  int errors = 0;

  alu_result_stage #(.N(4), .RW(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .result_i    (result_i),
    .cout_i      (cout_i),
    .overflow_i  (overflow_i),
    .rd_i        (rd_i),
    .set_flags_i (set_flags_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .rd_o        (rd_o),
    .flags_o     (flags_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic v, input logic [3:0] r, input logic [3:0] rd,
                       input logic c, input logic ov, input logic sf);
    in_valid_i  = v;
    result_i    = r;
    rd_i        = rd;
    cout_i      = c;
    overflow_i  = ov;
    set_flags_i = sf;
  endtask

  initial begin
    rst_i = 1'b1;
    flush_i = 1'b0;
    out_ready_i = 1'b0;
    offer(1'b1, 4'hA, 4'h1, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_flags", flags_o, 4'b0000);
    chk("rst_result", result_o, 0);
    chk("rst_rd", rd_o, 0);
    offer(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b0;

    // Pass-through with flag update
    out_ready_i = 1'b1;
    offer(1'b1, 4'h9, 4'h3, 1'b1, 1'b1, 1'b1);
    tick();
    offer(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("pt_valid", out_valid_o, 1);
    chk("pt_result", result_o, 4'h9);
    chk("pt_rd", rd_o, 4'h3);
    chk("pt_flags", flags_o, 4'b1011);
    tick();
    chk("pt_drained", out_valid_o, 0);

    // Zero result sets Z; set_flags=0 leaves flags alone
    offer(1'b1, 4'h0, 4'h5, 1'b0, 1'b0, 1'b1);
    tick();
    chk("zero_flags", flags_o, 4'b0100);
    chk("zero_valid", out_valid_o, 1);
    offer(1'b1, 4'h2, 4'h6, 1'b1, 1'b1, 1'b0);
    tick();
    chk("noset_flags", flags_o, 4'b0100);
    chk("noset_result", result_o, 4'h2);
    chk("noset_rd", rd_o, 4'h6);
    offer(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("noset_drained", out_valid_o, 0);

    // Backpressure: 1 and 2 accepted, 3 held off
    out_ready_i = 1'b0;
    offer(1'b1, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_in_ready1", in_ready_o, 1);
    offer(1'b1, 4'h2, 4'h2, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_in_ready2", in_ready_o, 0);
    chk("bp_result1", result_o, 4'h1);
    offer(1'b1, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_hold_result", result_o, 4'h1);
    chk("bp_hold_rd", rd_o, 4'h1);
    chk("bp_hold_ready", in_ready_o, 0);
    chk("bp_hold_valid", out_valid_o, 1);
    out_ready_i = 1'b1;
    tick();
    chk("bp_out2", result_o, 4'h2);
    chk("bp_out2_rd", rd_o, 4'h2);
    chk("bp_ready_back", in_ready_o, 1);
    tick();
    chk("bp_out3", result_o, 4'h3);
    chk("bp_out3_valid", out_valid_o, 1);
    offer(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_empty", out_valid_o, 0);
    chk("bp_flags_kept", flags_o, 4'b0100);

    // Drain and accept together with main only
    out_ready_i = 1'b0;
    offer(1'b1, 4'h7, 4'h7, 1'b0, 1'b0, 1'b0);
    tick();
    chk("da_main7", result_o, 4'h7);
    offer(1'b1, 4'h8, 4'h8, 1'b0, 1'b0, 1'b0);
    out_ready_i = 1'b1;
    tick();
    chk("da_result8", result_o, 4'h8);
    chk("da_in_ready", in_ready_o, 1);
    chk("da_valid", out_valid_o, 1);
    offer(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("da_empty", out_valid_o, 0);

    // Flush with both entries full
    out_ready_i = 1'b0;
    offer(1'b1, 4'hA, 4'h1, 1'b0, 1'b0, 1'b0);
    tick();
    offer(1'b1, 4'hB, 4'h2, 1'b0, 1'b0, 1'b0);
    tick();
    chk("fl_full", in_ready_o, 0);
    offer(1'b1, 4'hF, 4'h3, 1'b1, 1'b1, 1'b1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    offer(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("fl_valid", out_valid_o, 0);
    chk("fl_in_ready", in_ready_o, 1);
    chk("fl_flags", flags_o, 4'b0100);

    // Flush with main only: the concurrent accept is dropped, flags untouched
    offer(1'b1, 4'hA, 4'h1, 1'b0, 1'b0, 1'b0);
    tick();
    offer(1'b1, 4'hF, 4'h3, 1'b1, 1'b1, 1'b1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    offer(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("fl2_valid", out_valid_o, 0);
    chk("fl2_flags", flags_o, 4'b0100);
    tick();
    chk("fl2_still_empty", out_valid_o, 0);

    // Asynchronous reset mid-cycle with both entries occupied
    out_ready_i = 1'b0;
    offer(1'b1, 4'h5, 4'h4, 1'b1, 1'b0, 1'b1);
    tick();
    chk("ar_main5", result_o, 4'h5);
    chk("ar_flags", flags_o, 4'b0010);
    offer(1'b1, 4'h6, 4'h5, 1'b0, 1'b0, 1'b0);
    tick();
    chk("ar_full", in_ready_o, 0);
    #2;
    rst_i = 1'b1;
    #1;
    chk("ar_out_valid", out_valid_o, 0);
    chk("ar_flags0", flags_o, 4'b0000);
    chk("ar_in_ready", in_ready_o, 1);
    chk("ar_result0", result_o, 0);
    tick();
    rst_i = 1'b0;
    offer(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("ar_post_valid", out_valid_o, 0);
    chk("ar_post_ready", in_ready_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the arithmetic unit.
- Captures each ALU result together with its carry-out, overflow and destination register index.
- Holds the result in a 2-entry skid buffer with a valid/ready handshake toward writeback.
- Maintains the architectural NZCV flag register, updated from results that request a flag update.

Parameters:
- N, 4, datapath width; must match the ALU result width.
- RW, 4, width of the destination register index.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- in_valid_i  input  1  ALU presents a result this cycle.
- in_ready_o  output  1  stage can accept a result this cycle.
- result_i  input  N  ALU result.
- cout_i  input  1  ALU carry-out.
- overflow_i  input  1  ALU signed overflow.
- rd_i  input  RW  destination register index.
- set_flags_i  input  1  this result updates NZCV.
- flush_i  input  1  discard all buffered results (synchronous).
- out_valid_o  output  1  result_o and rd_o are valid.
- out_ready_i  input  1  writeback consumes the result this cycle.
- result_o  output  N  buffered result, oldest first.
- rd_o  output  RW  destination index paired with result_o.
- flags_o  output  4  architectural flags {N,Z,C,V}.

Behaviour:
Reset and clock:
- Clock is clk_i; reset is rst_i, asynchronous, active-high.
- While rst_i is high: main_valid=0, skid_valid=0, all data registers 0, flags_o=4'b0000, out_valid_o=0, result_o=0, rd_o=0, in_ready_o=1.
- Input activity while rst_i is high is ignored.
- Asserting rst_i mid-operation discards every entry immediately, with no further output.

Storage and handshake:
- Storage is two entries, main and skid, each holding {result, rd, valid}.
- Outputs are driven only from main.
- accept = in_valid_i & in_ready_o. drain = out_valid_o & out_ready_i.
- in_ready_o = ~skid_valid. It is a function of registered state only, with no combinational path from out_ready_i.
- out_valid_o = main_valid.
- Latency is 1 cycle: a result accepted at edge k appears on result_o after edge k, provided main was empty or drained at edge k.
- out_valid_o, result_o and rd_o stay stable until drain; rd and result are never altered while out_valid_o=1 and out_ready_i=0.

State transitions (priority top to bottom):
- flush_i=1: main_valid<=0, skid_valid<=0. Any accept in the same cycle is discarded and does not update flags. flags_o is retained.
- Empty (main_valid=0) with accept: main<=input.
- Main only, drain and accept: main<=input.
- Main only, drain without accept: main_valid<=0.
- Main only, accept without drain: skid<=input; in_ready_o falls next cycle.
- Full (both valid) with drain: main<=skid, skid_valid<=0. No accept is possible, since in_ready_o=0.
- Full without drain: hold.
- Order is strictly FIFO; at most 2 results in flight.

Flags:
- On accept with set_flags_i=1 and flush_i=0, at the same edge:
  - N<=result_i[N-1]
  - Z<=(result_i==0)
  - C<=cout_i
  - V<=overflow_i
- flags_o bit order is [3]=N, [2]=Z, [1]=C, [0]=V.
- Accept with set_flags_i=0 leaves flags unchanged.
- Flags update at accept time, independent of when writeback drains the entry.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle with main holding 4'h5 -> out_valid_o=0, flags_o=0000 and in_ready_o=1 immediately, without waiting for a clock edge.
- Pass-through: out_ready_i=1, accept result_i=4'h9, rd_i=3, cout=1, ovf=1, set_flags=1 -> next cycle out_valid_o=1, result_o=9, rd_o=3, flags_o=1011.
- Zero result: accept result_i=0 with set_flags=1, cout=0, ovf=0 -> flags_o=0100. Then accept 4'h2 with set_flags=0 -> flags_o stays 0100.
- Backpressure: out_ready_i=0, offer 4'h1, 4'h2, 4'h3 back-to-back.
  - 1 and 2 are accepted; in_ready_o=0 during the third offer, so 3 is held.
  - result_o stays 1.
  - Raise out_ready_i -> outputs 1, 2, then 3 accepted and output, with no loss or duplication.
- Simultaneous drain and accept with main only: main=4'h7, accept 4'h8 while out_ready_i=1 -> next cycle result_o=8, skid empty, in_ready_o=1.
- Flush: both entries full, flush_i=1 with in_valid_i=1 and set_flags_i=1 on result 4'hF -> next cycle out_valid_o=0, in_ready_o=1, flags_o unchanged.
